// File: rtl/keypad_entry_display.sv
// Pops key codes from the scanner FIFO, edits a BCD entry buffer and commits it on Enter.
// Also drives a multiplexed common-anode 7-segment display of the buffer.
module keypad_entry_display #(
  parameter int DIGITS      = 4,
  parameter int RD_LAT      = 1,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [7:0]            key_bcd,
  output logic                  key_read,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic                  entry_done,
  output logic                  err,
  output logic [3:0]            digit_count,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [LW-1:0] WAIT_LAST = LW'(RD_LAT - 1);
  localparam logic [3:0]    DIG_MAX   = 4'(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_APPLY} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       wcnt_q, wcnt_d;
  logic [7:0]          code_q, code_d;
  logic [4*DIGITS-1:0] buf_q, buf_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [CW-1:0]       ref_q, ref_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [3:0] tens, units;
  logic       code_ok;
  logic [4:0] key_v;
  logic [3:0] nib;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  assign tens    = code_q[7:4];
  assign units   = code_q[3:0];
  // Legal codes are 00..09 and 10..15 only.
  assign code_ok = (units <= 4'd9) && ((tens == 4'd0) || ((tens == 4'd1) && (units <= 4'd5)));
  assign key_v   = (tens == 4'd1) ? (5'(units) + 5'd10) : 5'(units);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) state_d = S_REQ;
      end
      S_REQ: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          code_d  = key_bcd;
          state_d = S_APPLY;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_APPLY: begin
        state_d = S_IDLE;
        if (!code_ok) begin
          err_d = 1'b1;
        end else if (key_v <= 5'd9) begin
          if (cnt_q < DIG_MAX) begin
            buf_d = {buf_q[4*DIGITS-5:0], key_v[3:0]};
            cnt_d = cnt_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_v == 5'd10) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (key_v == 5'd11) begin
          if (cnt_q != 4'd0) begin
            buf_d = {4'h0, buf_q[4*DIGITS-1:4]};
            cnt_d = cnt_q - 4'd1;
          end
        end else if (key_v == 5'd12) begin
          val_d  = buf_q;
          done_d = 1'b1;
          buf_d  = '0;
          cnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign nib = buf_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    an_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
    // Positions at or above the digit count stay blank, hiding leading zeros.
    seg_d = (4'(idx_q) < cnt_q) ? seg_of(nib) : 7'h7F;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      code_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign key_read    = (state_q == S_REQ);
  assign entry_value = val_q;
  assign entry_done  = done_q;
  assign err         = err_q;
  assign digit_count = cnt_q;
  assign seg         = seg_q;
  assign an          = an_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Bench for keypad_entry_display: FIFO-like key source, decimal-number model, per-cycle compare.
module tb_keypad_entry_display;
  localparam int DIGITS = 4;
  localparam int RD_LAT = 1;
  localparam int REF    = 4;

  logic clock = 1'b0;
  logic reset;
  logic key_valid;
  logic [7:0] key_bcd;
  logic key_read;
  logic [4*DIGITS-1:0] entry_value;
  logic entry_done, err;
  logic [3:0] digit_count;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;

  keypad_entry_display #(.DIGITS(DIGITS), .RD_LAT(RD_LAT), .REFRESH_DIV(REF)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_bcd(key_bcd),
    .key_read(key_read), .entry_value(entry_value), .entry_done(entry_done),
    .err(err), .digit_count(digit_count), .seg(seg), .an(an)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] kq[$];
  int rd_stamps[$];
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model: the buffer is held as the decimal number typed so far plus a digit count.
  int m_num, m_cnt, disp_num, disp_cnt, n_edges, cyc;
  logic [4*DIGITS-1:0] m_val;
  bit m_err, m_done;
  bit pend;
  int pend_pop;
  logic [7:0] pend_code;
  int err_seen, done_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int num);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((num / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int digit_at(input int num, input int pos);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    return (num / p) % 10;
  endfunction

  task automatic apply_key(input logic [7:0] code);
    int t, u, v;
    t = int'(code[7:4]);
    u = int'(code[3:0]);
    v = 10 * t + u;
    if (t > 1 || u > 9 || v > 15) m_err = 1'b1;
    else if (v <= 9) begin
      if (m_cnt < DIGITS) begin
        m_num = m_num * 10 + v;
        m_cnt++;
      end else m_err = 1'b1;
    end else if (v == 10) begin
      m_num = 0;
      m_cnt = 0;
    end else if (v == 11) begin
      if (m_cnt > 0) begin
        m_num = m_num / 10;
        m_cnt--;
      end
    end else if (v == 12) begin
      m_val  = to_bcd(m_num);
      m_done = 1'b1;
      m_num  = 0;
      m_cnt  = 0;
    end
  endtask

  // Key source plus per-cycle compare against the model.
  initial begin
    bit r_edge;
    int idx;
    logic [DIGITS-1:0] exp_an;
    logic [6:0] exp_seg;
    cyc = 0; pend = 0; n_edges = 0;
    m_num = 0; m_cnt = 0; m_val = '0; m_err = 0; m_done = 0;
    disp_num = 0; disp_cnt = 0; err_seen = 0; done_seen = 0;
    forever begin
      @(posedge clock);
      r_edge = reset;
      #1;
      cyc++;
      if (r_edge) pend = 1'b0;
      key_bcd = (pend && cyc == pend_pop + RD_LAT) ? pend_code : 8'hEE;
      @(negedge clock);
      if (r_edge) begin
        m_num = 0; m_cnt = 0; m_val = '0; m_err = 0; m_done = 0;
        disp_num = 0; disp_cnt = 0; n_edges = 0;
      end else begin
        n_edges++;
        disp_num = m_num;
        disp_cnt = m_cnt;
        m_err = 0;
        m_done = 0;
        if (pend && cyc == pend_pop + RD_LAT + 2) begin
          apply_key(pend_code);
          pend = 1'b0;
        end
      end
      check("err", err, m_err);
      check("entry_done", entry_done, m_done);
      check("entry_value", entry_value, m_val);
      check("digit_count", digit_count, m_cnt);
      if (n_edges == 0) begin
        exp_an = '1;
        exp_seg = 7'h7F;
      end else begin
        idx = ((n_edges - 1) / REF) % DIGITS;
        exp_an = ~(DIGITS'(1) << idx);
        exp_seg = (idx < disp_cnt) ? segtab[digit_at(disp_num, idx)] : 7'h7F;
      end
      check("an", an, exp_an);
      check("seg", seg, exp_seg);
      if (err) err_seen++;
      if (entry_done) done_seen++;
      if (r_edge || pend) check("key_read_busy", key_read, 1'b0);
      else if (key_read) begin
        if (kq.size() == 0) check("key_read_empty", key_read, 1'b0);
        else begin
          rd_stamps.push_back(cyc);
          pend = 1'b1;
          pend_pop = cyc;
          pend_code = kq.pop_front();
          key_valid = (kq.size() != 0);
        end
      end
    end
  end

  task automatic push(input logic [7:0] c);
    kq.push_back(c);
    key_valid = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((kq.size() != 0 || pend) && b < 300) begin
      @(posedge clock);
      b++;
    end
    if (b >= 300) check("drain_timeout", 32'(b), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int b;
    logic [6:0] want;
    bit [3:0] an_hit;
    reset = 1'b1;
    key_valid = 1'b1;
    key_bcd = 8'hEE;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("rst_key_read", key_read, 1'b0);
    end
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_count", digit_count, 4'd0);
    reset = 1'b0;
    key_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // 1,2,3, Enter
    err_seen = 0; done_seen = 0; rd_stamps.delete();
    push(8'h01); push(8'h02); push(8'h03); push(8'h12);
    drain();
    check("commit_value", entry_value, 16'h0123);
    check("commit_done_cnt", done_seen, 1);
    check("commit_count", digit_count, 4'd0);
    check("commit_err_cnt", err_seen, 0);
    check("read_pulses", rd_stamps.size(), 4);
    for (int i = 1; i < rd_stamps.size(); i++)
      check("read_spacing", rd_stamps[i] - rd_stamps[i-1], 4);

    // overflow
    err_seen = 0;
    repeat (5) push(8'h09);
    drain();
    check("full_count", digit_count, 4'd4);
    check("full_err_cnt", err_seen, 1);
    check("model_full_num", m_num, 9999);
    push(8'h10);
    drain();
    check("clear_count", digit_count, 4'd0);

    // backspace
    err_seen = 0;
    push(8'h05); push(8'h07); push(8'h11);
    drain();
    check("bs_count", digit_count, 4'd1);
    check("model_bs_num", m_num, 5);
    push(8'h11); push(8'h11);
    drain();
    check("bs_empty_count", digit_count, 4'd0);
    check("bs_err_cnt", err_seen, 0);

    // illegal and reserved codes
    push(8'h04);
    drain();
    err_seen = 0;
    push(8'h1A); push(8'h20);
    drain();
    check("bad_err_cnt", err_seen, 2);
    check("bad_count", digit_count, 4'd1);
    push(8'h14);
    drain();
    check("rsv_err_cnt", err_seen, 2);
    check("rsv_count", digit_count, 4'd1);

    // display scan of 0123
    push(8'h10); push(8'h01); push(8'h02); push(8'h03);
    drain();
    an_hit = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      #1;
      case (an)
        4'b1110: begin want = 7'h30; an_hit[0] = 1'b1; end
        4'b1101: begin want = 7'h24; an_hit[1] = 1'b1; end
        4'b1011: begin want = 7'h79; an_hit[2] = 1'b1; end
        4'b0111: begin want = 7'h7F; an_hit[3] = 1'b1; end
        default: want = 7'h7F;
      endcase
      check("scan_seg", seg, want);
    end
    check("scan_an_all", an_hit, 4'hF);
    done_seen = 0;
    push(8'h12);
    drain();
    check("scan_commit", entry_value, 16'h0123);
    check("scan_done_cnt", done_seen, 1);

    // reset during WAIT
    push(8'h08);
    drain();
    done_seen = 0;
    push(8'h12);
    b = 0;
    do begin
      @(posedge clock);
      #1;
      b++;
    end while (!key_read && b < 50);
    if (b >= 50) check("wait_read_timeout", 32'(b), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_key_read", key_read, 1'b0);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("abort_key_read_idle", key_read, 1'b0);
    check("abort_done_cnt", done_seen, 0);
    check("abort_value", entry_value, 16'h0000);
    check("abort_count", digit_count, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_entry_display.md
Name: keypad_entry_display

Overview:
- Downstream consumer of the keypad scanner/encoder top.
- Pops key codes through its read/valid handshake and interprets them as numeric entry and command keys.
- Maintains a DIGITS-wide BCD entry buffer and publishes the committed value on Enter.
- Drives a time-multiplexed, common-anode 7-segment display showing the buffer.

Parameters:
DIGITS, 4, number of BCD entry/display digits (2..8)
RD_LAT, 1, cycles from key_read pulse until key_bcd is valid (1..3)
REFRESH_DIV, 50000, clock cycles each display digit stays enabled (>=2)

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  high when scanner FIFO holds at least one code
key_bcd  input  8  two-digit BCD key code, [7:4] tens, [3:0] units
key_read  output  1  one-cycle pop request to scanner (drives its read)
entry_value  output  4*DIGITS  last committed buffer, digit 0 in [3:0]
entry_done  output  1  one-cycle pulse when entry_value updates
err  output  1  one-cycle pulse on rejected key
digit_count  output  4  digits currently in buffer (0..DIGITS)
seg  output  7  active-low segments {g,f,e,d,c,b,a}
an  output  DIGITS  active-low digit enables, one-hot-low

Behaviour:
- Reset (synchronous, active-high, clock named clock, reset named reset): FSM to IDLE; key_read=0, entry_done=0, err=0, entry_value=0, buffer=0, digit_count=0, an=all ones, seg=7'h7F, refresh counter and digit index=0. Reset mid-handshake aborts it; the popped code is discarded.
- Handshake FSM: IDLE -> REQ when key_valid=1. REQ: key_read=1 for exactly one cycle -> WAIT. WAIT: count RD_LAT cycles, then capture key_bcd -> APPLY. APPLY: execute key, -> IDLE. key_read is never asserted outside REQ. Back-to-back keys take RD_LAT+3 cycles each. key_valid is ignored outside IDLE.
- Decode: key value v = 10*tens+units. Valid only if tens<=1, units<=9, v<=15; otherwise err pulses in APPLY and nothing else changes.
- v=0..9, digit: if digit_count<DIGITS, shift buffer left one nibble, insert v at digit 0, digit_count++. Else err pulses; buffer unchanged.
- v=10, clear: buffer=0, digit_count=0.
- v=11, backspace: if digit_count>0, shift buffer right one nibble, zero top nibble, digit_count--. At 0, no-op, no err.
- v=12, enter: entry_value<=buffer, entry_done pulses one cycle, then buffer=0, digit_count=0. Enter with count 0 commits 0.
- v=13..15: reserved; ignored, no err.
- err and entry_done are registered; both assert in the cycle after APPLY and last one cycle.
- Display: refresh counter counts 0..REFRESH_DIV-1. On wrap, digit index advances 0..DIGITS-1 and wraps to 0. an[idx]=0, all other bits 1.
- Digit idx < digit_count shows buffer nibble idx; otherwise blank (7'h7F). Leading positions are therefore blank, and count 0 shows all blank.
- seg and an are registered together, so there is no mismatch glitch.
- Segment codes (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex). Buffer nibbles are always 0..9.

Test Plan:
- Reset held 3 cycles with key_valid=1 -> key_read stays 0; seg=7F, an=all 1s, digit_count=0.
- Keys 0x01,0x02,0x03 then 0x12, RD_LAT=1 -> key_read pulses once per key, exactly 4 cycles apart when key_valid stays high. entry_value=16'h0123, entry_done pulses once, digit_count returns to 0.
- Keys 0x09 x5 with DIGITS=4 -> buffer 9999, digit_count=4; fifth key gives one err pulse and the buffer is unchanged.
- Keys 0x05,0x07,0x11,0x11,0x11 -> count 2, then 1 (buffer 0005), then 0; third backspace gives no err. Key 0x10 after digits -> count 0.
- Key 0x1A and key 0x20 -> one err pulse each; buffer and count unchanged. Key 0x14 -> no err, no change.
- REFRESH_DIV=4, buffer 0123 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg 30,24,79,7F respectively. Reset asserted during WAIT -> FSM in IDLE next cycle, no entry_done.
